// File: rtl/mvm_accum.sv
// mvm_accum: row accumulator behind the 8-lane dot-product stage.
// It sums cfg_num_chunks consecutive signed partials into one output element
// and queues finished elements in a first-word-fall-through FIFO. The upstream
// stage cannot be stalled, so an element that completes while the queue is
// full and not popping is dropped, and the sticky overflow flag is raised.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   cfg_num_chunks  chunks per element (0 behaves as 1), latched at element start
//   idata, ivalid   signed partial sum and its valid strobe (no ready upstream)
//   odata, ovalid   head of queue (0 when empty) and queue non-empty
//   oready          consumer accept; pop on ovalid && oready
//   full            queue holds FIFO_DEPTH entries
//   overflow        sticky: a finished element was dropped
//   busy            a partially accumulated element is in progress
//
// Handshake: ivalid is a one-sided strobe that is always consumed. On the output
// side, a transfer happens on every rising edge where ovalid && oready. odata is
// held stable while ovalid=1 and oready=0.
module mvm_accum #(
   parameter int IWIDTH     = 32,
   parameter int OWIDTH     = 32,
   parameter int MAX_CHUNKS = 16,
   parameter int CWIDTH     = $clog2(MAX_CHUNKS + 1),
   parameter int FIFO_DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CWIDTH-1:0]        cfg_num_chunks,
   input  logic signed [IWIDTH-1:0] idata,
   input  logic                     ivalid,
   output logic signed [OWIDTH-1:0] odata,
   output logic                     ovalid,
   input  logic                     oready,
   output logic                     full,
   output logic                     overflow,
   output logic                     busy
);

   localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNTW = PW + 1;

   // Accumulator state
   logic [CWIDTH-1:0]        cnt_q, cnt_d;
   logic [CWIDTH-1:0]        n_lat_q, n_lat_d;
   logic signed [OWIDTH-1:0] acc_q, acc_d;

   // FIFO state
   logic signed [OWIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
   logic [CNTW-1:0]          count_q, count_d;
   logic                     ovalid_q, full_q, overflow_q;

   logic [CWIDTH-1:0]        n_eff;
   logic [CWIDTH-1:0]        n_cur;
   logic signed [OWIDTH-1:0] idata_ext;
   logic signed [OWIDTH-1:0] sum;
   logic                     complete;
   logic                     pop;
   logic                     push_ok;
   logic                     drop;

   // Sign-extending size cast; also correct when OWIDTH == IWIDTH.
   assign idata_ext = OWIDTH'(idata);
   assign n_eff     = (cfg_num_chunks == '0) ? CWIDTH'(1) : cfg_num_chunks;

   // The first chunk of an element uses the live config; later chunks use the
   // latched count so mid-element config changes have no effect.
   assign n_cur     = (cnt_q == '0) ? n_eff : n_lat_q;
   assign sum       = (cnt_q == '0) ? idata_ext : acc_q + idata_ext;
   assign complete  = ivalid && (cnt_q == n_cur - CWIDTH'(1));

   assign pop       = ovalid_q && oready;
   // A pop in the same cycle frees the slot, so a full queue still accepts.
   assign push_ok   = complete && ((count_q != CNTW'(FIFO_DEPTH)) || pop);
   assign drop      = complete && !push_ok;

   always_comb begin
      cnt_d   = cnt_q;
      n_lat_d = n_lat_q;
      acc_d   = acc_q;
      if (ivalid) begin
         acc_d = sum;
         if (cnt_q == '0) n_lat_d = n_eff;
         cnt_d = complete ? '0 : cnt_q + CWIDTH'(1);
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         n_lat_q    <= CWIDTH'(1);
         acc_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovalid_q   <= 1'b0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         n_lat_q  <= n_lat_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
         ovalid_q <= (count_d != '0);
         full_q   <= (count_d == CNTW'(FIFO_DEPTH));
         if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
         if (drop)    overflow_q <= 1'b1;
      end
   end

   // Storage needs no reset: reads are masked while the queue is empty.
   always_ff @(posedge clk) begin
      if (!rst && push_ok) mem_q[wr_ptr_q] <= sum;
   end

   assign odata    = ovalid_q ? mem_q[rd_ptr_q] : '0;
   assign ovalid   = ovalid_q;
   assign full     = full_q;
   assign overflow = overflow_q;
   assign busy     = (cnt_q != '0);

endmodule
